// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int CNT_W = 4;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write, combinational read, same index.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_idx,
   input  logic [31:0]   i_wd,
   input  logic [3:0]    i_be,
   output logic [31:0]   o_rd
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (i_we && i_be[k]) begin
            mem[i_idx][8*k +: 8] <= i_wd[8*k +: 8];
         end
      end
   end

   assign o_rd = mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory load/store interface with programmable wait states.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag non-word-aligned accesses as errors.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_Valid,
   output logic        o_Ready,
   input  logic        i_Wen,
   input  logic [31:0] i_Addr,
   input  logic [31:0] i_Wd,
   input  logic [3:0]  i_Be,
   output logic        o_RValid,
   input  logic        i_RReady,
   output logic [31:0] o_Rd,
   output logic        o_Err
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             rvalid_q, rvalid_d;
   logic [31:0]      rd_q, rd_d;
   logic             err_q, err_d;

   logic [AW-1:0] idx;
   logic          out_of_range;
   logic          misalign;
   logic          req_err;
   logic          accept;
   logic          we;
   logic [31:0]   mem_rd;

   assign idx          = i_Addr[AW+1:2];
   assign out_of_range = |i_Addr[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = |i_Addr[1:0];
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = &{1'b0, i_Addr[1:0]};
   assign misalign        = 1'b0;
`endif

   assign req_err = out_of_range | misalign;
   assign accept  = i_Valid & ready_q;
   assign we      = accept & i_Wen & ~req_err & (i_Be != BE_NONE);

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .i_clk (i_clk),
      .i_we  (we),
      .i_idx (idx),
      .i_wd  (i_Wd),
      .i_be  (i_Be),
      .o_rd  (mem_rd)
   );

   // WAIT is always entered and counts LATENCY down to 0, so the response
   // becomes visible LATENCY+1 edges after the accepting edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      rvalid_d = rvalid_q;
      rd_d     = rd_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WAIT;
               cnt_d   = LAT_INIT;
               ready_d = 1'b0;
               err_d   = req_err;
               rd_d    = (req_err || i_Wen) ? 32'd0 : mem_rd;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d  = RESP;
               rvalid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (i_RReady) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
               ready_d  = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            ready_d  = 1'b1;
            rvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rd_q     <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rd_q     <= rd_d;
         err_q    <= err_d;
      end
   end

   assign o_Ready  = ready_q;
   assign o_RValid = rvalid_q;
   assign o_Rd     = rd_q;
   assign o_Err    = err_q;

endmodule
